// File: rtl/two_port_ram.sv
// Two-port synchronous RAM, write-first on both ports, port A wins on a same-address
// write collision; the collision is reported one cycle later.
module two_port_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] douta_r;
  logic [DATA_W-1:0] doutb_r;
  logic              collision_r;

  logic              same_addr_s;
  logic              collide_s;
  logic              web_eff_s;
  logic [DATA_W-1:0] douta_next_s;
  logic [DATA_W-1:0] doutb_next_s;

  // Collision detection and write-first read data for both ports.
  always_comb begin
    same_addr_s  = (addra == addrb);
    collide_s    = wea & web & same_addr_s;
    web_eff_s    = web & ~collide_s;
    douta_next_s = mem_r[addra];
    doutb_next_s = mem_r[addrb];
    if (wea) begin
      douta_next_s = dina;
    end else if (web && same_addr_s) begin
      douta_next_s = dinb;
    end else begin
      douta_next_s = mem_r[addra];
    end
    // Port A's write data takes precedence for the port B reader as well.
    if (wea && same_addr_s) begin
      doutb_next_s = dina;
    end else if (web) begin
      doutb_next_s = dinb;
    end else begin
      doutb_next_s = mem_r[addrb];
    end
  end

  // Storage array: synchronous clear, then independent writes from each port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (web_eff_s) begin
        mem_r[addrb] <= dinb;
      end
      if (wea) begin
        mem_r[addra] <= dina;
      end
    end
  end

  // Registered read data and collision flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      douta_r     <= {DATA_W{1'b0}};
      doutb_r     <= {DATA_W{1'b0}};
      collision_r <= 1'b0;
    end else begin
      douta_r     <= douta_next_s;
      doutb_r     <= doutb_next_s;
      collision_r <= collide_s;
    end
  end

  assign douta     = douta_r;
  assign doutb     = doutb_r;
  assign collision = collision_r;

endmodule

// File: tb/tb_two_port_ram.sv
// Directed bench for two_port_ram: reset, per-port write/read, dual writes,
// same-address collision and reset during a write.
module tb_two_port_ram;

  logic       clk;
  logic       rst_n;
  logic       wea;
  logic [1:0] addra;
  logic [3:0] dina;
  logic [3:0] douta;
  logic       web;
  logic [1:0] addrb;
  logic [3:0] dinb;
  logic [3:0] doutb;
  logic       collision;

  int checks = 0;
  int errors = 0;

  two_port_ram #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta),
    .web       (web),
    .addrb     (addrb),
    .dinb      (dinb),
    .doutb     (doutb),
    .collision (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wea = 1'b0; web = 1'b0;
    addra = 2'd0; addrb = 2'd0; dina = 4'b0000; dinb = 4'b0000;

    // Reset for two edges
    cyc(); cyc();
    check("rst_douta", douta, 4'b0000);
    check("rst_doutb", doutb, 4'b0000);
    check("rst_collision", {3'b000, collision}, 4'b0000);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addra = 2'(i);
      addrb = 2'(3 - i);
      cyc();
      check("rst_read_a", douta, 4'b0000);
      check("rst_read_b", doutb, 4'b0000);
    end

    // Port A write then hold
    wea = 1'b1; addra = 2'd0; dina = 4'b1010; addrb = 2'd2;
    cyc();
    check("a_write_first", douta, 4'b1010);
    wea = 1'b0;
    cyc();
    check("a_read_hold", douta, 4'b1010);

    // Port B write, then cross-port read
    web = 1'b1; addrb = 2'd1; dinb = 4'b0101; addra = 2'd0;
    cyc();
    check("b_write_first", doutb, 4'b0101);
    check("a_read_during_b", douta, 4'b1010);
    web = 1'b0; addra = 2'd1;
    cyc();
    check("a_cross_read", douta, 4'b0101);

    // Dual write, distinct addresses
    wea = 1'b1; web = 1'b1; addra = 2'd2; dina = 4'b1111; addrb = 2'd3; dinb = 4'b0010;
    cyc();
    check("dual_collision", {3'b000, collision}, 4'b0000);
    check("dual_douta", douta, 4'b1111);
    check("dual_doutb", doutb, 4'b0010);
    wea = 1'b0; web = 1'b0;
    cyc();
    check("dual_mem2", douta, 4'b1111);
    check("dual_mem3", doutb, 4'b0010);

    // B writes addr 3 while A reads it
    web = 1'b1; addrb = 2'd3; dinb = 4'b1000; addra = 2'd3;
    cyc();
    check("b_wr_a_sees", douta, 4'b1000);
    check("b_wr_b_sees", doutb, 4'b1000);
    web = 1'b0; addra = 2'd2;
    cyc();
    check("mem2_unchanged", douta, 4'b1111);
    check("mem3_updated", doutb, 4'b1000);

    // A writes addr 1 while B reads it
    wea = 1'b1; addra = 2'd1; dina = 4'b0011; addrb = 2'd1;
    cyc();
    check("a_wr_b_sees", doutb, 4'b0011);
    check("a_wr_a_sees", douta, 4'b0011);
    wea = 1'b0;

    // Same-address collision: port A wins
    wea = 1'b1; web = 1'b1; addra = 2'd3; addrb = 2'd3; dina = 4'b0000; dinb = 4'b0110;
    cyc();
    check("coll_flag", {3'b000, collision}, 4'b0001);
    check("coll_douta", douta, 4'b0000);
    check("coll_doutb", doutb, 4'b0000);
    wea = 1'b0; web = 1'b0;
    cyc();
    check("coll_flag_clear", {3'b000, collision}, 4'b0000);
    check("coll_mem3_a", douta, 4'b0000);
    check("coll_mem3_b", doutb, 4'b0000);

    // Confirm other words before mid-operation reset
    addra = 2'd0; addrb = 2'd1;
    cyc();
    check("pre_rst_mem0", douta, 4'b1010);
    check("pre_rst_mem1", doutb, 4'b0011);

    // Reset on an edge with a pending write
    rst_n = 1'b0; wea = 1'b1; addra = 2'd0; dina = 4'b1111; addrb = 2'd2;
    cyc();
    check("mid_rst_douta", douta, 4'b0000);
    check("mid_rst_doutb", doutb, 4'b0000);
    rst_n = 1'b1; wea = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addra = 2'(i);
      addrb = 2'(3 - i);
      cyc();
      check("mid_rst_read_a", douta, 4'b0000);
      check("mid_rst_read_b", doutb, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
